mtm_alu_cmd_serializer: RTL and testbench
=========================================

# mtm_alu_cmd_serializer

Synthesizable stimulus-side serializer for the mtm_Alu serial protocol. It accepts one ALU command (operands A and B, 3-bit opcode) over a valid/ready handshake and drives it onto the ALU `sin` line: eight data frames followed by one CMD frame carrying the opcode and a CRC4. It sits in the bench or system top in place of the BFM's driver, and its output connects directly to the DUT `sin` port.

## Interface
- No parameters.
- `clk` in 1: single clock; one serial bit per cycle.
- `rst_n` in 1: synchronous, active-low reset.
- `a_i` in 32: operand A, sampled at accept.
- `b_i` in 32: operand B, sampled at accept.
- `op_i` in 3: opcode, sampled at accept.
- `crc_flip_i` in 1: error injection, sampled at accept; 1 means transmit CRC with bit 0 inverted.
- `valid_i` in 1: command request.
- `ready_o` out 1: block is idle and will accept a command this cycle.
- `sin_o` out 1: serial line to DUT `sin`; idle level 1.
- `done_o` out 1: one-cycle pulse marking the last (stop) bit of the CMD frame.

## Operation
- **Frame format** (11 bits, MSB first):
  - start bit 0;
  - type bit (0 = data, 1 = CMD);
  - 8 payload bits, bit7 first;
  - stop bit 1.
- **Frame order**: B[31:24], B[23:16], B[15:8], B[7:0], A[31:24], A[23:16], A[15:8], A[7:0], then CMD.
- **CMD payload**: {1'b0, op[2:0], crc[3:0]}.
- **CRC4**:
  - Polynomial x^4+x+1, init 4'b0000.
  - Message, MSB first: B[31:0], A[31:0], 1'b1, op[2:0] (68 bits).
  - Serial update per bit d: fb = crc[3]^d; crc = {crc[2:0],1'b0} ^ (fb ? 4'b0011 : 4'b0000).
  - CRC may be computed combinationally at accept or serially during the data frames. It must be final before the CMD payload starts.
  - If `crc_flip_i` was 1 at accept, transmit crc ^ 4'b0001.
- **Accept**: a command is accepted on a rising edge with valid_i && ready_o. All inputs are captured into internal registers; later input changes have no effect.
- **FSM**:
  - IDLE: sin_o=1, ready_o=1. On accept, go to START.
  - START: 1 cycle, sin_o=0.
  - TYPE: 1 cycle, sin_o = (frame==8).
  - PAYLOAD: 8 cycles, MSB first.
  - STOP: 1 cycle, sin_o=1. If frame<8, increment the frame counter and go to START; otherwise assert done_o and go to IDLE.
- **Counters**: frame counter 0..8; bit counter 0..7. Neither wraps beyond its range.
- sin_o is driven from a register; no combinational path from any input to sin_o.

## Timing
- **Reset values**: sin_o=1, ready_o=1, done_o=0, FSM=IDLE, all counters 0.
- Accept at edge T:
  - ready_o=0 from T.
  - Start bit of frame 0 on sin_o during cycle T+1.
- **Transaction length**: 99 cycles on sin_o (9 frames × 11 bits).
- **Frames are back-to-back**: the stop bit of frame n is immediately followed by the start bit of frame n+1, with no idle bits.
- **done_o**: high exactly during the cycle the CMD stop bit is on sin_o (cycle T+99).
- ready_o returns to 1 at cycle T+100. A new accept at that edge yields a start bit at T+101, so there is at least one idle-high bit between commands.
- **valid_i while busy**: ignored; nothing is queued.
- **Reset mid-transaction**: at the next edge with rst_n=0, all state returns to reset values, sin_o=1 immediately, and the partial command is discarded. No done_o is produced.
- **valid_i during reset**: ignored. The first possible accept is the first edge with rst_n=1.

## Test plan
- **Reset**: hold rst_n=0 for 3 cycles, then release -> sin_o=1, ready_o=1, done_o=0 throughout.
- **All-zero AND**: A=0, B=0, op=000 -> 8 data frames 0_0_00000000_1, then CMD 0_1_00001011_1 (crc 4'b1011). done_o pulses at T+99.
- **All-zero ADD**: A=0, B=0, op=100 -> CMD payload 8'h47 (crc 4'b0111).
- **Byte order**:
  - Stimulus: A=32'h01020304, B=32'hA0B0C0D0, op=001.
  - Payload order: A0, B0, C0, D0, 01, 02, 03, 04, then CMD.
  - CMD CRC must match the reference model.
- **CRC flip**: repeat the all-zero AND case with crc_flip_i=1 -> CMD payload 8'h0A. All other bits are unchanged.
- **Back-to-back and reset abort**:
  - Hold valid_i=1 continuously -> accepts occur exactly 100 cycles apart, with one idle-high bit between commands.
  - Assert rst_n=0 in frame 3 -> sin_o=1 from the next cycle, no done_o, and a clean new command after release.

Source files
------------

// File: rtl/mtm_alu_cmd_serializer.sv
// mtm_alu_cmd_serializer
//   Drives one mtm_Alu command onto the ALU serial input: eight data frames
//   (B bytes then A bytes, MSB byte first) followed by a CMD frame carrying
//   {0, op, crc4}. Each frame is start(0), type, 8 payload bits MSB first,
//   and stop(1).
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   a_i, b_i     : operands, captured at accept
//   op_i         : opcode, captured at accept
//   crc_flip_i   : when 1 at accept, CRC bit 0 is sent inverted
//   valid_i      : command request
//   ready_o      : idle, a command is accepted on this edge if valid_i
//   sin_o        : registered serial line, idles high
//   done_o       : pulse coincident with the CMD stop bit
module mtm_alu_cmd_serializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  input  logic        crc_flip_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        sin_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_TYPE, S_PAYLOAD, S_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  frame_q, frame_d;
  logic [2:0]  bit_q, bit_d;
  logic [31:0] a_q, b_q;
  logic [2:0]  op_q;
  logic [3:0]  crc_q;
  logic        sin_q, sin_d;
  logic        done_q, done_d;
  logic [7:0]  payload;
  logic        accept;

  // Serial CRC4 (x^4+x+1, init 0) over {B, A, 1'b1, op}, MSB first.
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  assign ready_o = (state_q == S_IDLE);
  assign accept  = valid_i && ready_o;
  assign sin_o   = sin_q;
  assign done_o  = done_q;

  // Command capture; the transmitted CRC already includes the flip.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      crc_q <= '0;
    end else if (accept) begin
      a_q   <= a_i;
      b_q   <= b_i;
      op_q  <= op_i;
      crc_q <= crc4({b_i, a_i, 1'b1, op_i}) ^ {3'b000, crc_flip_i};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          frame_d = '0;
          bit_d   = '0;
        end
      end
      S_START: state_d = S_TYPE;
      S_TYPE: begin
        state_d = S_PAYLOAD;
        bit_d   = '0;
      end
      S_PAYLOAD: begin
        if (bit_q == 3'd7) begin
          state_d = S_STOP;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (frame_q < 4'd8) begin
          state_d = S_START;
          frame_d = frame_q + 4'd1;
        end else begin
          state_d = S_IDLE;
          frame_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        frame_d = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Payload byte of the current frame
  always_comb begin
    payload = 8'h00;
    case (frame_q)
      4'd0:    payload = b_q[31:24];
      4'd1:    payload = b_q[23:16];
      4'd2:    payload = b_q[15:8];
      4'd3:    payload = b_q[7:0];
      4'd4:    payload = a_q[31:24];
      4'd5:    payload = a_q[23:16];
      4'd6:    payload = a_q[15:8];
      4'd7:    payload = a_q[7:0];
      default: payload = {1'b0, op_q, crc_q};
    endcase
  end

  // Output logic. sin/done are registered, so the line lags the state by
  // one cycle: the accept cycle itself still shows idle-high.
  always_comb begin
    sin_d  = 1'b1;
    done_d = 1'b0;
    case (state_q)
      S_IDLE:    sin_d = 1'b1;
      S_START:   sin_d = 1'b0;
      S_TYPE:    sin_d = (frame_q == 4'd8);
      S_PAYLOAD: sin_d = payload[3'd7 - bit_q];
      S_STOP: begin
        sin_d  = 1'b1;
        done_d = (frame_q == 4'd8);
      end
      default:   sin_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sin_q  <= 1'b1;
      done_q <= 1'b0;
    end else begin
      sin_q  <= sin_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_mtm_alu_cmd_serializer.sv
// Bench for mtm_alu_cmd_serializer: a transaction-level model builds the
// 99-bit line image of every accepted command and the expected handshake
// timing; a negedge process checks sin/ready/done against it every cycle.
// Directed cases additionally check decoded payload bytes against literals.
module tb_mtm_alu_cmd_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a_i = '0, b_i = '0;
  logic [2:0]  op_i = '0;
  logic        crc_flip_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o, sin_o, done_o;

  int total = 0;
  int bad   = 0;

  mtm_alu_cmd_serializer dut (
    .clk(clk), .rst_n(rst_n), .a_i(a_i), .b_i(b_i), .op_i(op_i),
    .crc_flip_i(crc_flip_i), .valid_i(valid_i), .ready_o(ready_o),
    .sin_o(sin_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // CRC as the remainder of msg*x^4 divided by x^4+x+1.
  function automatic logic [3:0] crc_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
    logic [71:0] r;
    r = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  // Full line image of one command, first transmitted bit at index 98.
  function automatic logic [98:0] build(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op, input logic flip);
    logic [98:0] s;
    logic [63:0] data;
    logic [7:0]  by;
    data = {b, a};
    s = '0;
    for (int f = 0; f < 9; f++) begin
      if (f < 8) by = data[63-8*f -: 8];
      else       by = {1'b0, op, crc_model(a, b, op) ^ {3'b000, flip}};
      s[98-11*f -: 11] = {1'b0, (f == 8), by, 1'b1};
    end
    return s;
  endfunction

  // Model: k = cycles since the accepting edge, -1 when idle.
  int          cyc = 0;
  int          k = -1;
  logic [98:0] exp_bits = '0;
  int          acc_times[$];

  always @(posedge clk) begin
    bit mready;
    cyc++;
    mready = (k < 0) || (k >= 99);
    if (!rst_n) k = -1;
    else if (valid_i && mready) begin
      k = 0;
      exp_bits = build(a_i, b_i, op_i, crc_flip_i);
      acc_times.push_back(cyc);
    end else if (k >= 0) begin
      k++;
      if (k > 99) k = -1;
    end
  end

  // Receiver: the last 99 line bits, snapshotted when done is high.
  logic [98:0] rx_win = '0;
  logic [98:0] cap = '0;
  int          done_cnt = 0;

  always @(posedge clk) begin
    if (done_o === 1'b1) begin
      cap = {rx_win[97:0], sin_o};
      done_cnt++;
    end
    rx_win = {rx_win[97:0], sin_o};
  end

  // Per-cycle compare
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("sin",   {31'b0, sin_o},   {31'b0, (k >= 1 && k <= 99) ? exp_bits[99-k] : 1'b1});
      chk("ready", {31'b0, ready_o}, {31'b0, (k < 0) || (k >= 99)});
      chk("done",  {31'b0, done_o},  {31'b0, (k == 99)});
    end
  end

  task automatic start_cmd(input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic flip);
    int n;
    @(posedge clk); #1;
    a_i = a; b_i = b; op_i = op; crc_flip_i = flip; valid_i = 1'b1;
    n = 0;
    while (ready_o !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", {31'b0, (n < 200)}, 32'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    a_i = ~a; b_i = ~b; op_i = ~op; crc_flip_i = ~flip;  // must be ignored
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_timeout", {31'b0, (n < 200)}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_frames(input string nm, input logic [63:0] data, input logic [7:0] cmd);
    for (int f = 0; f < 8; f++)
      chk($sformatf("%s_data%0d", nm, f), {24'b0, cap[96-11*f -: 8]}, {24'b0, data[63-8*f -: 8]});
    chk({nm, "_type"}, {31'b0, cap[9]}, 32'd1);
    chk({nm, "_cmd"},  {24'b0, cap[8:1]}, {24'b0, cmd});
  endtask

  initial begin
    int n, dc;
    // Reset for 3 cycles with valid asserted: must be ignored.
    valid_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    valid_i = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // All-zero AND
    start_cmd(32'h0, 32'h0, 3'b000, 1'b0);
    wait_done();
    chk_frames("and0", 64'h0, 8'h0B);

    // All-zero ADD
    start_cmd(32'h0, 32'h0, 3'b100, 1'b0);
    wait_done();
    chk_frames("add0", 64'h0, 8'h47);

    // Byte order
    start_cmd(32'h01020304, 32'hA0B0C0D0, 3'b001, 1'b0);
    wait_done();
    chk_frames("order", 64'hA0B0C0D0_01020304,
               {1'b0, 3'b001, crc_model(32'h01020304, 32'hA0B0C0D0, 3'b001)});

    // CRC flip
    start_cmd(32'h0, 32'h0, 3'b000, 1'b1);
    wait_done();
    chk_frames("flip", 64'h0, 8'h0A);

    // Back-to-back with valid held high and inputs changing every cycle
    repeat (3) @(posedge clk);
    acc_times.delete();
    #1;
    valid_i = 1'b1;
    n = 0;
    while (acc_times.size() < 3 && n < 400) begin
      @(posedge clk); #1;
      a_i = $urandom; b_i = $urandom; op_i = 3'($urandom); crc_flip_i = 1'($urandom);
      n++;
    end
    valid_i = 1'b0;
    chk("b2b_count", acc_times.size(), 32'd3);
    if (acc_times.size() >= 3) begin
      chk("b2b_gap1", acc_times[1] - acc_times[0], 32'd100);
      chk("b2b_gap2", acc_times[2] - acc_times[1], 32'd100);
    end
    wait_done();

    // Reset abort during frame 3
    dc = done_cnt;
    start_cmd(32'h11223344, 32'h55667788, 3'b101, 1'b0);
    repeat (37) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (120) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, dc);

    // Clean command after the abort
    start_cmd(32'h0, 32'h0, 3'b100, 1'b0);
    wait_done();
    chk_frames("post", 64'h0, 8'h47);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
